quad_decoder_8bit: RTL and testbench

QUAD_DECODER_8BIT -- requirements
Module: quad_decoder_8bit

---
 rtl/quad_decoder_8bit.sv | 154 +++++++++++++++
 tb/tb_quad_decoder_8bit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_8bit.sv
// Quadrature encoder decoder with 8-bit wrap-around position counter.
//
// Each encoder channel is synchronized through a SYNC_STAGES-deep flop chain,
// then debounced by a glitch filter that only accepts a new level once it has
// been stable for FILT_CYCLES consecutive clocks. The filtered pair {a,b} is
// compared against the previous filtered state to classify each change as an
// up step, a down step, or an illegal (both-bits) transition.
//
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   synchronous active-high reset
//   enc_a    in   quadrature channel A (asynchronous)
//   enc_b    in   quadrature channel B (asynchronous)
//   en       in   count enable
//   clr      in   synchronous clear of position and err
//   position out  8-bit wrap-around position count
//   step     out  one-cycle pulse per accepted valid transition
//   dir      out  direction of last accepted transition (1 up, 0 down)
//   err      out  sticky illegal-transition flag
module quad_decoder_8bit #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] position,
  output logic       step,
  output logic       dir,
  output logic       err
);

  localparam int WARM_CYCLES = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  // Forward (up) sequence: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   fwd_next = 2'b10;
      2'b10:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b01;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  // Modulo-256 position update; wrap-around is intentional.
  function automatic logic [7:0] wrap_step(input logic [7:0] pos, input logic up);
    wrap_step = up ? (pos + 8'd1) : (pos - 8'd1);
  endfunction

  // Stage p0: input synchronizers (first flop samples the raw pin)
  logic [SYNC_STAGES-1:0] sync_a_p0;
  logic [SYNC_STAGES-1:0] sync_b_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_p0 <= '0;
      sync_b_p0 <= '0;
    end else begin
      sync_a_p0 <= {sync_a_p0[SYNC_STAGES-2:0], enc_a};
      sync_b_p0 <= {sync_b_p0[SYNC_STAGES-2:0], enc_b};
    end
  end

  logic sa_p0;
  logic sb_p0;
  assign sa_p0 = sync_a_p0[SYNC_STAGES-1];
  assign sb_p0 = sync_b_p0[SYNC_STAGES-1];

  // Stage p1: glitch filters
  logic       filt_a_p1;
  logic       filt_b_p1;
  logic [3:0] cnt_a_p1;
  logic [3:0] cnt_b_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_a_p1 <= 1'b0;
      filt_b_p1 <= 1'b0;
      cnt_a_p1  <= 4'd0;
      cnt_b_p1  <= 4'd0;
    end else begin
      if (sa_p0 == filt_a_p1) begin
        cnt_a_p1 <= 4'd0;
      end else if (cnt_a_p1 == 4'(FILT_CYCLES - 1)) begin
        filt_a_p1 <= sa_p0;
        cnt_a_p1  <= 4'd0;
      end else begin
        cnt_a_p1 <= cnt_a_p1 + 4'd1;
      end

      if (sb_p0 == filt_b_p1) begin
        cnt_b_p1 <= 4'd0;
      end else if (cnt_b_p1 == 4'(FILT_CYCLES - 1)) begin
        filt_b_p1 <= sb_p0;
        cnt_b_p1  <= 4'd0;
      end else begin
        cnt_b_p1 <= cnt_b_p1 + 4'd1;
      end
    end
  end

  // Transition classification against the last filtered state
  logic [1:0] cur_st;
  logic [1:0] last_st_p2;
  logic       is_up;
  logic       is_dn;
  logic       is_bad;

  always_comb begin
    cur_st = {filt_a_p1, filt_b_p1};
    is_up  = (cur_st == fwd_next(last_st_p2));
    is_dn  = (last_st_p2 == fwd_next(cur_st));
    is_bad = ((cur_st ^ last_st_p2) == 2'b11);
  end

  // Stage p2: last-state tracking, position and status outputs
  logic [WARM_W-1:0] warm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_st_p2 <= 2'b00;
      warm_cnt   <= WARM_W'(WARM_CYCLES);
      position   <= 8'h00;
      step       <= 1'b0;
      dir        <= 1'b1;
      err        <= 1'b0;
    end else begin
      // Last state always follows the filter so that re-enabling or clearing
      // never produces a catch-up step.
      last_st_p2 <= cur_st;
      step       <= 1'b0;
      if (warm_cnt != '0) begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end
      if (clr) begin
        position <= 8'h00;
        err      <= 1'b0;
      end else if (warm_cnt == '0) begin
        if (is_bad) begin
          err <= 1'b1;
        end else if (en && (is_up || is_dn)) begin
          position <= wrap_step(position, is_up);
          step     <= 1'b1;
          dir      <= is_up;
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder_8bit.sv
// Scoreboard bench for quad_decoder_8bit: stimulus pushes expected step events
// (position, dir, edge number) into a queue; a monitor pops and compares each
// time the DUT pulses step.
module tb_quad_decoder_8bit;

  localparam int LAT = 2 + 4;  // SYNC_STAGES + FILT_CYCLES at defaults

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_a;
  logic       enc_b;
  logic       en;
  logic       clr;
  logic [7:0] position;
  logic       step;
  logic       dir;
  logic       err;

  quad_decoder_8bit dut (
    .clk      (clk),
    .rst      (rst),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .en       (en),
    .clr      (clr),
    .position (position),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pos;
    logic       dir;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the decoder's filtered state
  logic [7:0] m_pos;
  logic       m_dir;
  logic [1:0] m_st;

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   fwd = 2'b10;
      2'b10:   fwd = 2'b11;
      2'b11:   fwd = 2'b01;
      default: fwd = 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the next posedge is edge N = cyc+1, step expected at N+LAT.
  task automatic drive(input logic a, input logic b);
    logic [1:0] st;
    exp_t e;
    st    = {a, b};
    enc_a = a;
    enc_b = b;
    if (en && st == fwd(m_st)) begin
      m_pos = m_pos + 8'd1;
      m_dir = 1'b1;
      e.pos = m_pos; e.dir = 1'b1; e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end else if (en && m_st == fwd(st)) begin
      m_pos = m_pos - 8'd1;
      m_dir = 1'b0;
      e.pos = m_pos; e.dir = 1'b0; e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    m_st = st;
  endtask

  task automatic move(input logic a, input logic b, input int n);
    drive(a, b);
    hold(n);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    hold(1);
    clr = 1'b0;
    m_pos = 8'h00;
  endtask

  // Monitor
  logic prev_step = 1'b0;
  always @(negedge clk) begin
    if (!rst && step === 1'b1) begin
      exp_t e;
      if (prev_step) begin
        checks++;
        errors++;
        $display("FAIL step_double: step high two cycles at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got step=1 expected none (cycle %0d, pos 0x%0h)", cyc, position);
      end else begin
        e = sb.pop_front();
        chk("step_pos", int'(position), int'(e.pos));
        chk("step_dir", int'(dir), int'(e.dir));
        chk("step_cycle", cyc, e.cyc);
      end
    end
    prev_step <= step;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; en = 1'b1; clr = 1'b0;
    m_pos = 8'h00; m_dir = 1'b1; m_st = 2'b11;
    @(negedge clk);
    hold(3);
    chk("rst_position", int'(position), 'h00);
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    hold(14);
    chk("warm_position", int'(position), 'h00);
    chk("warm_err", int'(err), 0);

    // 11 -> 01 -> 00 are up steps
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    chk("pre_pos", int'(position), 'h02);
    do_clr();
    chk("clr_pos", int'(position), 'h00);

    // Four forward steps
    move(1'b1, 1'b0, 10);
    move(1'b1, 1'b1, 10);
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    chk("fwd4_pos", int'(position), 'h04);
    chk("fwd4_dir", int'(dir), 1);

    // Wrap down then 256 steps up
    do_clr();
    move(1'b0, 1'b1, 10);
    chk("wrap_dn_pos", int'(position), 'hFF);
    chk("wrap_dn_dir", int'(dir), 0);
    for (int i = 0; i < 64; i++) begin
      move(1'b0, 1'b0, 8);
      move(1'b1, 1'b0, 8);
      move(1'b1, 1'b1, 8);
      move(1'b0, 1'b1, 8);
    end
    chk("wrap256_pos", int'(position), 'hFF);
    chk("wrap256_dir", int'(dir), 1);

    // 3-cycle glitch on A: filtered out
    enc_a = 1'b1;
    hold(3);
    enc_a = 1'b0;
    hold(12);
    chk("glitch3_pos", int'(position), 'hFF);
    // 4-cycle pulse: accepted (down) then reversed (up)
    drive(1'b1, 1'b1);
    hold(4);
    drive(1'b0, 1'b1);
    hold(12);
    chk("pulse4_pos", int'(position), 'hFF);
    chk("pulse4_dir", int'(dir), 1);

    // Illegal 00 -> 11
    move(1'b0, 1'b0, 10);
    chk("pre_err_pos", int'(position), 'h00);
    move(1'b1, 1'b1, 10);
    chk("illegal_err", int'(err), 1);
    chk("illegal_pos", int'(position), 'h00);
    do_clr();
    chk("clr_err", int'(err), 0);
    chk("clr_err_pos", int'(position), 'h00);

    // Disabled motion, then re-enable without catch-up
    en = 1'b0;
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    move(1'b1, 1'b0, 10);
    en = 1'b1;
    hold(10);
    chk("en_frozen_pos", int'(position), 'h00);
    move(1'b1, 1'b1, 10);
    chk("en_resume_pos", int'(position), 'h01);
    chk("en_resume_dir", int'(dir), 1);

    // Reset in the middle of a pending filter count
    enc_a = 1'b0;
    hold(3);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    m_pos = 8'h00; m_dir = 1'b1; m_st = 2'b01;
    hold(16);
    chk("midrst_pos", int'(position), 'h00);
    chk("midrst_dir", int'(dir), 1);
    chk("midrst_err", int'(err), 0);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      hold(1);
      t++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
